// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: shadow pipeline of pending GPR/HI-LO/CP0 writes
// producing the ID stall, operand forwarding selects and the divider interlock.
module hazard_scoreboard #(
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned FWD_EN      = 1,
  parameter int unsigned DIV_LATENCY = 32,
  localparam int unsigned SELW       = $clog2(NUM_STAGES) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_w_rf,
  input  logic              id_load,
  input  logic              id_r_hilo,
  input  logic              id_w_hilo,
  input  logic              id_div,
  input  logic              id_r_cp0,
  input  logic              id_w_cp0,
  input  logic              flush,
  output logic              stall,
  output logic              issue,
  output logic [SELW-1:0]   fwd_rs_sel,
  output logic [SELW-1:0]   fwd_rt_sel,
  output logic              hilo_busy,
  output logic [5:0]        div_count
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              w_rf;
    logic              load;
    logic              w_hilo;
    logic              w_cp0;
  } entry_t;

  entry_t [NUM_STAGES-1:0] ent_q, ent_d;
  logic [5:0]              cnt_q, cnt_d;
  logic                    busy_q, busy_d;

  logic            rs_hit, rt_hit, rs_load, rt_load, rs_stall, rt_stall;
  logic [SELW-1:0] rs_k, rt_k;
  logic            hilo_pend, cp0_pend, hazard;

  function automatic logic gpr_match(input entry_t e, input logic [REG_AW-1:0] src,
                                     input logic used);
    return e.valid && e.w_rf && (e.rd != '0) && (e.rd == src) && used;
  endfunction

  // Youngest match wins: scan from EXE outward and latch the first hit.
  // The WB entry is left out because the regfile bypasses write-to-read.
  always_comb begin
    rs_hit  = 1'b0;
    rs_k    = '0;
    rs_load = 1'b0;
    rt_hit  = 1'b0;
    rt_k    = '0;
    rt_load = 1'b0;
    for (int unsigned k = 0; k < NUM_STAGES - 1; k++) begin
      if (!rs_hit && gpr_match(ent_q[k], id_rs, id_rs_used)) begin
        rs_hit  = 1'b1;
        rs_k    = SELW'(k);
        rs_load = ent_q[k].load;
      end
      if (!rt_hit && gpr_match(ent_q[k], id_rt, id_rt_used)) begin
        rt_hit  = 1'b1;
        rt_k    = SELW'(k);
        rt_load = ent_q[k].load;
      end
    end
  end

  always_comb begin
    hilo_pend = 1'b0;
    cp0_pend  = 1'b0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      if (ent_q[k].valid && ent_q[k].w_hilo) hilo_pend = 1'b1;
      if (ent_q[k].valid && ent_q[k].w_cp0)  cp0_pend  = 1'b1;
    end
  end

  always_comb begin
    if (FWD_EN != 0) begin
      rs_stall = rs_hit && rs_load && (rs_k == '0);
      rt_stall = rt_hit && rt_load && (rt_k == '0);
    end else begin
      rs_stall = rs_hit;
      rt_stall = rt_hit;
    end
    hazard = rs_stall || rt_stall
          || (id_r_hilo && (hilo_pend || busy_q))
          || ((id_w_hilo || id_div) && busy_q)
          || (id_r_cp0 && cp0_pend);
    stall = id_valid && hazard;
    issue = id_valid && !hazard;
    fwd_rs_sel = '0;
    fwd_rt_sel = '0;
    if (FWD_EN != 0 && !stall) begin
      if (rs_hit) fwd_rs_sel = rs_k + SELW'(1);
      if (rt_hit) fwd_rt_sel = rt_k + SELW'(1);
    end
  end

  always_comb begin
    ent_d = '0;
    if (!flush) begin
      if (issue) begin
        ent_d[0].valid  = 1'b1;
        ent_d[0].rd     = id_rd;
        ent_d[0].w_rf   = id_w_rf;
        ent_d[0].load   = id_load;
        ent_d[0].w_hilo = id_w_hilo;
        ent_d[0].w_cp0  = id_w_cp0;
      end
      for (int unsigned k = 1; k < NUM_STAGES; k++) ent_d[k] = ent_q[k-1];
    end
  end

  // The divider cannot be aborted, so flush only blocks a new load.
  always_comb begin
    cnt_d = cnt_q;
    if (issue && id_div && !flush) cnt_d = 6'(DIV_LATENCY);
    else if (cnt_q != '0)          cnt_d = cnt_q - 6'd1;
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      ent_q  <= ent_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign hilo_busy = busy_q;
  assign div_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: three instances (defaults, no forwarding,
// short divider) share one stimulus stream and are reset between scenarios.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_w_rf, id_load;
  logic       id_r_hilo, id_w_hilo, id_div, id_r_cp0, id_w_cp0, flush;
  logic [4:0] id_rs, id_rt, id_rd;

  logic       d_stall, d_issue, d_busy;
  logic [2:0] d_rs_sel, d_rt_sel;
  logic [5:0] d_cnt;
  logic       n_stall, n_issue, n_busy;
  logic [2:0] n_rs_sel, n_rt_sel;
  logic [5:0] n_cnt;
  logic       q_stall, q_issue, q_busy;
  logic [2:0] q_rs_sel, q_rt_sel;
  logic [5:0] q_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_scoreboard u_def (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_w_rf(id_w_rf),
    .id_load(id_load), .id_r_hilo(id_r_hilo), .id_w_hilo(id_w_hilo), .id_div(id_div),
    .id_r_cp0(id_r_cp0), .id_w_cp0(id_w_cp0), .flush(flush), .stall(d_stall),
    .issue(d_issue), .fwd_rs_sel(d_rs_sel), .fwd_rt_sel(d_rt_sel), .hilo_busy(d_busy),
    .div_count(d_cnt)
  );

  hazard_scoreboard #(.FWD_EN(0)) u_nf (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_w_rf(id_w_rf),
    .id_load(id_load), .id_r_hilo(id_r_hilo), .id_w_hilo(id_w_hilo), .id_div(id_div),
    .id_r_cp0(id_r_cp0), .id_w_cp0(id_w_cp0), .flush(flush), .stall(n_stall),
    .issue(n_issue), .fwd_rs_sel(n_rs_sel), .fwd_rt_sel(n_rt_sel), .hilo_busy(n_busy),
    .div_count(n_cnt)
  );

  hazard_scoreboard #(.DIV_LATENCY(4)) u_d4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_w_rf(id_w_rf),
    .id_load(id_load), .id_r_hilo(id_r_hilo), .id_w_hilo(id_w_hilo), .id_div(id_div),
    .id_r_cp0(id_r_cp0), .id_w_cp0(id_w_cp0), .flush(flush), .stall(q_stall),
    .issue(q_issue), .fwd_rs_sel(q_rs_sel), .fwd_rt_sel(q_rt_sel), .hilo_busy(q_busy),
    .div_count(q_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    id_rd = 0; id_w_rf = 0; id_load = 0; id_r_hilo = 0; id_w_hilo = 0;
    id_div = 0; id_r_cp0 = 0; id_w_cp0 = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic producer(input logic [4:0] rd, input logic ld);
    idle();
    id_valid = 1; id_rd = rd; id_w_rf = 1; id_load = ld;
  endtask

  task automatic reader(input logic [4:0] rs, input logic [4:0] rt);
    idle();
    id_valid = 1; id_rs = rs; id_rt = rt; id_rs_used = 1; id_rt_used = 1;
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    // Reset state, checked while reset is still asserted
    id_valid = 1;
    settle();
    chk("rst_stall", d_stall, 0);
    chk("rst_issue", d_issue, 1);
    chk("rst_rs_sel", d_rs_sel, 0);
    chk("rst_busy", d_busy, 0);
    chk("rst_cnt", d_cnt, 0);
    do_reset();

    // ALU producer forwarded from EXE, then MEM, then excluded at WB
    producer(5'd3, 0); settle();
    chk("alu_issue", d_issue, 1);
    tick();
    reader(5'd3, 5'd9); settle();
    chk("fwd1_stall", d_stall, 0);
    chk("fwd1_rs_sel", d_rs_sel, 1);
    chk("fwd1_rt_sel", d_rt_sel, 0);
    tick();
    settle();
    chk("fwd2_rs_sel", d_rs_sel, 2);
    tick();
    settle();
    chk("wb_excl_rs_sel", d_rs_sel, 0);
    chk("wb_excl_stall", d_stall, 0);

    // Youngest match decides
    do_reset();
    producer(5'd8, 0); tick();
    producer(5'd8, 0); tick();
    reader(5'd0, 5'd8); settle();
    chk("youngest_rt_sel", d_rt_sel, 1);

    // Load-use: one bubble then forward from MEM
    do_reset();
    producer(5'd5, 1); tick();
    reader(5'd0, 5'd5); settle();
    chk("lu_stall", d_stall, 1);
    chk("lu_issue", d_issue, 0);
    chk("lu_rt_sel", d_rt_sel, 0);
    tick();
    settle();
    chk("lu2_stall", d_stall, 0);
    chk("lu2_issue", d_issue, 1);
    chk("lu2_rt_sel", d_rt_sel, 2);

    // No forwarding: stall for two cycles, issue on the third with sel 0
    do_reset();
    producer(5'd4, 0); tick();
    reader(5'd4, 5'd0); settle();
    chk("nf_stall0", n_stall, 1);
    tick(); settle();
    chk("nf_stall1", n_stall, 1);
    chk("nf_sel1", n_rs_sel, 0);
    tick(); settle();
    chk("nf_stall2", n_stall, 0);
    chk("nf_issue2", n_issue, 1);
    chk("nf_sel2", n_rs_sel, 0);

    // $0 never matches
    do_reset();
    producer(5'd0, 0); tick();
    reader(5'd0, 5'd0); settle();
    chk("r0_stall", d_stall, 0);
    chk("r0_rs_sel", d_rs_sel, 0);
    chk("r0_rt_sel", d_rt_sel, 0);

    // Divider with DIV_LATENCY=4 followed by mflo
    do_reset();
    idle(); id_valid = 1; id_div = 1; settle();
    chk("div_issue", q_issue, 1);
    tick();
    idle(); id_valid = 1; id_r_hilo = 1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("div_cnt", q_cnt, 4 - i);
      chk("div_busy", q_busy, (i < 4) ? 1 : 0);
      chk("mflo_stall", q_stall, (i < 4) ? 1 : 0);
      if (i == 1) begin
        id_r_hilo = 0; id_w_hilo = 1; settle();
        chk("waw_stall", q_stall, 1);
        id_w_hilo = 0; id_r_hilo = 1;
      end
      tick();
    end

    // HI/LO write in flight blocks mfhi through WB
    do_reset();
    idle(); id_valid = 1; id_w_hilo = 1; tick();
    idle(); id_valid = 1; id_r_hilo = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("hilo_pipe_stall", d_stall, (i < 3) ? 1 : 0);
      tick();
    end

    // CP0 write pending blocks mfc0
    do_reset();
    idle(); id_valid = 1; id_w_cp0 = 1; tick();
    idle(); id_valid = 1; id_r_cp0 = 1; settle();
    chk("cp0_stall", d_stall, 1);

    // Flush squashes pending producer and the ID instruction; divider keeps counting
    do_reset();
    idle(); id_valid = 1; id_div = 1; tick();
    producer(5'd6, 0); tick();
    producer(5'd6, 0); flush = 1; settle();
    chk("flush_nostall", d_stall, 0);
    tick();
    reader(5'd6, 5'd6); settle();
    chk("flush_stall", d_stall, 0);
    chk("flush_rs_sel", d_rs_sel, 0);
    chk("flush_rt_sel", d_rt_sel, 0);
    chk("flush_cnt", d_cnt, 30);

    // Reset mid-divide with a live producer
    do_reset();
    idle(); id_valid = 1; id_div = 1; tick();
    producer(5'd2, 0); tick();
    idle(); rst = 1; tick();
    rst = 0;
    reader(5'd2, 5'd0); id_r_hilo = 1; settle();
    chk("rmd_busy", q_busy, 0);
    chk("rmd_cnt", q_cnt, 0);
    chk("rmd_stall", q_stall, 0);
    chk("rmd_rs_sel", q_rs_sel, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the combinational stall logic inside the CPU control decoder.
- Holds a shadow pipeline of pending GPR, HI/LO and CP0 writes for the stages after ID. From it the block generates the ID stall, per-operand forwarding selects, and a multi-cycle divider busy interlock.
- Sits beside the decoder in ID. Its stall output drives the IF/ID hold and the ID/EXE bubble insertion.

Parameters:
NUM_STAGES, 3, number of stages after ID that are tracked (entry 0 = EXE, entry NUM_STAGES-1 = WB); minimum 2
REG_AW, 5, GPR address width
FWD_EN, 1, 1 = forwarding enabled; 0 = stall on every in-window match
DIV_LATENCY, 32, cycles HI/LO stay busy after a divide issues; range 1..63

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_rs / id_rt  in  REG_AW  source register addresses
id_rs_used / id_rt_used  in  1  instruction reads rs / rt
id_rd  in  REG_AW  destination GPR
id_w_rf  in  1  instruction writes the GPR file
id_load  in  1  GPR result is available only after MEM
id_r_hilo  in  1  instruction reads HI/LO (mfhi/mflo)
id_w_hilo  in  1  instruction writes HI/LO through the pipeline (mult/mthi/mtlo)
id_div  in  1  instruction starts the multi-cycle divider
id_r_cp0  in  1  instruction reads CP0 (mfc0/eret)
id_w_cp0  in  1  instruction writes CP0
flush  in  1  squash all tracked younger instructions (exception/eret)
stall  out  1  hold IF/ID and bubble EXE
issue  out  1  id_valid && !stall
fwd_rs_sel / fwd_rt_sel  out  clog2(NUM_STAGES)+1  0 = regfile; k = forward from entry k-1
hilo_busy  out  1  divider result pending
div_count  out  6  remaining divider cycles

Behaviour:
- Entry record: {valid, rd, w_rf, load, w_hilo, w_cp0}. Every cycle the entries shift, entry[k] <= entry[k-1].
- Entry[0] is loaded from the ID inputs when issue=1; otherwise it is loaded as a bubble (valid=0).
- flush=1: every entry becomes invalid next cycle and no issue is recorded, so flush dominates issue. The divider counter is NOT cleared, because the divider cannot be aborted.
- Hazard window is entries 0..NUM_STAGES-2. The WB entry is excluded because the regfile bypasses write-to-read internally.
- GPR match: entry valid && w_rf && rd!=0 && rd==src && src_used. Address 0 never matches.
- Youngest match (lowest index) decides. Older matches to the same address are ignored.
- FWD_EN=1:
  - Non-load match at entry k: forward, sel=k+1.
  - Load match at entry 0: stall.
  - Load match at entry k>=1: forward, sel=k+1.
- FWD_EN=0: any match gives stall, and sel is always 0.
- sel=0 whenever stall=1 or there is no match.
- HI/LO: id_r_hilo stalls if any valid entry in 0..NUM_STAGES-1 has w_hilo, or if hilo_busy. HI/LO is never forwarded.
- id_w_hilo or id_div while hilo_busy: stall, giving WAW ordering with the divider.
- CP0: id_r_cp0 stalls while any valid entry in 0..NUM_STAGES-1 has w_cp0.
- Divider counter:
  - Loads DIV_LATENCY on the cycle after a div issue (issue && id_div && !flush).
  - Then decrements by 1 per cycle while nonzero.
  - hilo_busy = (count!=0), registered.
  - When count is 1 in cycle t, hilo_busy=1 in t and 0 in t+1; a dependent mfhi issues in t+1.
- stall = id_valid && (any hazard above). stall is combinational from ID inputs plus registered state, with no dependency on flush. id_valid=0 gives stall=0 and issue=0.
- Reset: all entries invalid, counter 0. Outputs are then stall=0, issue=id_valid, sel=0, hilo_busy=0, div_count=0.
- Reset mid-divide abandons the count.

Test Plan:
- Defaults: addu $3 issues (rd=3, w_rf), next instruction reads rs=3 -> stall=0, fwd_rs_sel=1. One cycle later a different instruction with rs=3 -> fwd_rs_sel=2.
- lw $5 issues, next instruction reads rt=5 -> stall=1 for exactly one cycle, then fwd_rt_sel=2 with issue=1.
- FWD_EN=0, NUM_STAGES=3: addu $4, then a reader of $4 -> stall for 2 cycles. Issues on the 3rd cycle with sel=0.
- rd=0 producer followed by a reader of $0 -> no stall, sel=0.
- DIV_LATENCY=4: div issues, then mflo immediately -> div_count goes 4,3,2,1,0 and hilo_busy goes 1,1,1,1,0. mflo issues on the cycle div_count=0.
- Producer in entry 0 with flush=1 -> next cycle all entries invalid; a reader of that rd sees stall=0 and sel=0. Divider count is unaffected.
- rst asserted mid-divide with entries valid -> next cycle hilo_busy=0, div_count=0, no stalls.
